vga_timing_gen: RTL and testbench

//  Parametrised VGA raster timing generator; successor to the fixed 50 MHz sync generator.

---
 rtl/vga_timing_gen.sv | 123 ++++++++++++
 tb/tb_vga_timing_gen.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
// A clock divider produces one advance edge every CLK_DIV clocks. On that
// edge the raster position steps, and Valid plus both syncs are registered
// from the new position, so every output changes on the same clock edge.
// A resync request restarts the raster like a reset but keeps frame_count.
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int X_W      = 11,
  parameter int Y_W      = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           resync,
  output logic [X_W-1:0] CounterX,
  output logic [Y_W-1:0] CounterY,
  output logic           Valid,
  output logic           vga_h_sync,
  output logic           vga_v_sync,
  output logic           pix_ce,
  output logic           line_start,
  output logic           frame_start,
  output logic [15:0]    frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [X_W-1:0] X_LAST   = X_W'(H_TOTAL - 1);
  localparam logic [X_W-1:0] X_ACT    = X_W'(H_ACTIVE);
  localparam logic [X_W-1:0] HS_BEGIN = X_W'(H_ACTIVE + H_FP);
  localparam logic [X_W-1:0] HS_END   = X_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [Y_W-1:0] Y_LAST   = Y_W'(V_TOTAL - 1);
  localparam logic [Y_W-1:0] Y_ACT    = Y_W'(V_ACTIVE);
  localparam logic [Y_W-1:0] VS_BEGIN = Y_W'(V_ACTIVE + V_FP);
  localparam logic [Y_W-1:0] VS_END   = Y_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  // Active levels; the idle level of each sync is the complement.
  localparam logic H_ON = (H_POL != 0);
  localparam logic V_ON = (V_POL != 0);

  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] divNext;
  logic             advance;
  logic             xWrap;
  logic             yWrap;
  logic [X_W-1:0]   nextX;
  logic [Y_W-1:0]   nextY;
  logic             nextValid;
  logic             nextH;
  logic             nextV;

  // Next raster position and the sync/valid levels that belong to it.
  always_comb begin
    advance   = (div == DIV_LAST);
    divNext   = advance ? '0 : div + DIV_W'(1);
    xWrap     = (CounterX == X_LAST);
    yWrap     = (CounterY == Y_LAST);
    nextX     = xWrap ? '0 : CounterX + X_W'(1);
    nextY     = CounterY;
    if (xWrap) begin
      nextY = yWrap ? '0 : CounterY + Y_W'(1);
    end
    nextValid = (nextX < X_ACT) && (nextY < Y_ACT);
    nextH     = ((nextX >= HS_BEGIN) && (nextX < HS_END)) ? H_ON : ~H_ON;
    // nextY only moves when X wraps, so vsync can only change as X becomes 0.
    nextV     = ((nextY >= VS_BEGIN) && (nextY < VS_END)) ? V_ON : ~V_ON;
  end

  // Divider, raster position, registered decode, strobes and frame counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div         <= '0;
      CounterX    <= X_LAST;
      CounterY    <= Y_LAST;
      Valid       <= 1'b0;
      vga_h_sync  <= ~H_ON;
      vga_v_sync  <= ~V_ON;
      pix_ce      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= 16'hFFFF;
    end else if (resync) begin
      // Same restart point as reset; frame_count keeps its value.
      div         <= '0;
      CounterX    <= X_LAST;
      CounterY    <= Y_LAST;
      Valid       <= 1'b0;
      vga_h_sync  <= ~H_ON;
      vga_v_sync  <= ~V_ON;
      pix_ce      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div         <= divNext;
      pix_ce      <= advance;
      line_start  <= advance && xWrap;
      frame_start <= advance && xWrap && yWrap;
      if (advance) begin
        CounterX   <= nextX;
        CounterY   <= nextY;
        Valid      <= nextValid;
        vga_h_sync <= nextH;
        vga_v_sync <= nextV;
        if (xWrap && yWrap) begin
          frame_count <= frame_count + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: two small configurations (pixel every clock
// with active-high syncs, and divide-by-3 with active-low syncs) driven by a
// shared clock, reset and resync, checked against an arithmetic raster model.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic resync = 1'b0;

  always #5 clk = ~clk;

  logic [10:0] xA, xB;
  logic [9:0]  yA, yB;
  logic        validA, hsA, vsA, pceA, lsA, fsA;
  logic        validB, hsB, vsB, pceB, lsB, fsB;
  logic [15:0] fcA, fcB;

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .H_POL(1), .V_POL(1),
    .X_W(11), .Y_W(10)
  ) dutA (
    .clk(clk), .rst_n(rst_n), .resync(resync),
    .CounterX(xA), .CounterY(yA), .Valid(validA),
    .vga_h_sync(hsA), .vga_v_sync(vsA), .pix_ce(pceA),
    .line_start(lsA), .frame_start(fsA), .frame_count(fcA)
  );

  vga_timing_gen #(
    .CLK_DIV(3), .H_ACTIVE(6), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2), .H_POL(0), .V_POL(0),
    .X_W(11), .Y_W(10)
  ) dutB (
    .clk(clk), .rst_n(rst_n), .resync(resync),
    .CounterX(xB), .CounterY(yB), .Valid(validB),
    .vga_h_sync(hsB), .vga_v_sync(vsB), .pix_ce(pceB),
    .line_start(lsB), .frame_start(fsB), .frame_count(fcB)
  );

  int checks = 0;
  int errors = 0;

  function automatic void check(string name, logic [47:0] act, logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endfunction

  // Reference: after t clocks since restart there have been t/cd advances;
  // advance n lands on linear pixel index (n-1) mod total, index -1 being
  // the restart position (last pixel of the frame).
  function automatic logic [26:0] refState(int t, int cd, int ha, int hf, int hsw,
                                           int hb, int va, int vf, int vsw, int vb,
                                           int hp, int vp);
    int ht, vt, n, p, x, y;
    logic pce, hAct, vAct, val;
    ht   = ha + hf + hsw + hb;
    vt   = va + vf + vsw + vb;
    n    = t / cd;
    p    = (n + ht * vt - 1) % (ht * vt);
    x    = p % ht;
    y    = p / ht;
    pce  = (t > 0) && (t % cd == 0);
    hAct = (x >= ha + hf) && (x < ha + hf + hsw);
    vAct = (y >= va + vf) && (y < va + vf + vsw);
    val  = (x < ha) && (y < va);
    return {11'(x), 10'(y), val, hAct ? (hp != 0) : (hp == 0),
            vAct ? (vp != 0) : (vp == 0), pce, pce && (x == 0), pce && (p == 0)};
  endfunction

  function automatic logic [26:0] expA(int t);
    return refState(t, 1, 4, 1, 2, 1, 3, 1, 1, 1, 1, 1);
  endfunction

  function automatic logic [26:0] expB(int t);
    return refState(t, 3, 6, 2, 3, 2, 4, 1, 2, 2, 0, 0);
  endfunction

  function automatic logic fsOfA(int t);
    logic [26:0] v;
    v = expA(t);
    return v[0];
  endfunction

  function automatic logic fsOfB(int t);
    logic [26:0] v;
    v = expB(t);
    return v[0];
  endfunction

  // Model time base: clocks since the last reset or resync edge.
  int tA = 0;
  int tB = 0;
  logic [15:0] mFcA = 16'hFFFF;
  logic [15:0] mFcB = 16'hFFFF;

  // Track restart time and frame counts for the model.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tA <= 0;
      tB <= 0;
      mFcA <= 16'hFFFF;
      mFcB <= 16'hFFFF;
    end else if (resync) begin
      tA <= 0;
      tB <= 0;
    end else begin
      tA <= tA + 1;
      tB <= tB + 1;
      if (fsOfA(tA + 1)) mFcA <= mFcA + 16'd1;
      if (fsOfB(tB + 1)) mFcB <= mFcB + 16'd1;
    end
  end

  // Advance to the next falling edge and compare both DUTs with the model.
  task automatic tick();
    @(negedge clk);
    check("modelA", 48'({fcA, xA, yA, validA, hsA, vsA, pceA, lsA, fsA}),
          48'({mFcA, expA(tA)}));
    check("modelB", 48'({fcB, xB, yB, validB, hsB, vsB, pceB, lsB, fsB}),
          48'({mFcB, expB(tB)}));
  endtask

  typedef struct {
    int          k;
    logic [10:0] x;
    logic [9:0]  y;
    logic        valid;
    logic        hs;
    logic        vs;
    logic        fs;
    logic [15:0] fc;
  } vec_t;

  vec_t tbl[12];
  int   cur;
  int   hold;
  logic found;

  initial begin
    // Hand-derived raster for dutA (H total 8, hsync X=5..6; V total 6, vsync Y=4).
    tbl[0]  = '{0,  11'd7, 10'd5, 1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFF};
    tbl[1]  = '{1,  11'd0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000};
    tbl[2]  = '{4,  11'd3, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
    tbl[3]  = '{5,  11'd4, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
    tbl[4]  = '{6,  11'd5, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
    tbl[5]  = '{7,  11'd6, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
    tbl[6]  = '{8,  11'd7, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
    tbl[7]  = '{9,  11'd0, 10'd1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
    tbl[8]  = '{33, 11'd0, 10'd4, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000};
    tbl[9]  = '{40, 11'd7, 10'd4, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000};
    tbl[10] = '{41, 11'd0, 10'd5, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
    tbl[11] = '{49, 11'd0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0001};

    #1 rst_n = 1'b0;
    tick();
    tick();
    check("resetB", 48'({xB, yB, validB, hsB, vsB, pceB, lsB, fsB, fcB}),
          48'({11'd12, 10'd8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF}));
    rst_n = 1'b1;

    // Table phase on dutA, k = clock edges since reset release.
    cur = 0;
    for (int i = 0; i < 12; i++) begin
      while (cur < tbl[i].k) begin
        tick();
        cur++;
      end
      check($sformatf("tblA_k%0d", tbl[i].k),
            48'({xA, yA, validA, hsA, vsA, fsA, fcA}),
            48'({tbl[i].x, tbl[i].y, tbl[i].valid, tbl[i].hs, tbl[i].vs,
                 tbl[i].fs, tbl[i].fc}));
    end

    // First frame of dutB after reset: frame_start CLK_DIV clocks later.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("b_k1", 48'({xB, pceB, fsB}), 48'({11'd12, 1'b0, 1'b0}));
    tick();
    check("b_k2", 48'({xB, pceB, fsB}), 48'({11'd12, 1'b0, 1'b0}));
    tick();
    check("b_k3", 48'({xB, yB, validB, pceB, fsB, fcB}),
          48'({11'd0, 10'd0, 1'b1, 1'b1, 1'b1, 16'h0000}));
    tick();
    check("b_k4", 48'({xB, pceB, fsB}), 48'({11'd0, 1'b0, 1'b0}));

    // Run to k=204 (dutB at X=2,Y=5; dutA has started 5 frames), then resync.
    repeat (200) tick();
    check("b_k204", 48'({xB, yB, fcA}), 48'({11'd2, 10'd5, 16'd4}));
    resync = 1'b1;
    tick();
    resync = 1'b0;
    check("resyncB", 48'({xB, yB, validB, hsB, vsB, pceB, fsB, fcB}),
          48'({11'd12, 10'd8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000}));
    check("resyncA", 48'({xA, yA, validA, hsA, vsA, fcA}),
          48'({11'd7, 10'd5, 1'b0, 1'b0, 1'b0, 16'd4}));
    tick();
    check("resyncA_fs", 48'({xA, yA, fsA, fcA}), 48'({11'd0, 10'd0, 1'b1, 16'd5}));
    check("resyncB_e1", 48'({fsB, pceB}), 48'({1'b0, 1'b0}));
    tick();
    check("resyncB_e2", 48'({fsB, pceB}), 48'({1'b0, 1'b0}));
    tick();
    check("resyncB_fs", 48'({xB, yB, fsB, fcB}), 48'({11'd0, 10'd0, 1'b1, 16'd1}));

    // Asynchronous reset while dutB is inside its hsync pulse.
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (hsB == 1'b0) found = 1'b1;
      else tick();
    end
    check("hsyncSeen", 48'(found), 48'(1'b1));
    #1 rst_n = 1'b0;
    #1;
    check("asyncRstB", 48'({hsB, xB, yB, validB, pceB, lsB, fsB, fcB}),
          48'({1'b1, 11'd12, 10'd8, 1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFF}));
    check("asyncRstA", 48'({hsA, vsA, xA, yA, validA, fcA}),
          48'({1'b0, 1'b0, 11'd7, 10'd5, 1'b0, 16'hFFFF}));
    tick();
    rst_n = 1'b1;

    // Random resync bursts and occasional asynchronous reset pulses.
    hold = 0;
    for (int c = 0; c < 20000; c++) begin
      tick();
      if (hold > 0) hold--;
      else if ($urandom_range(0, 79) == 0) hold = $urandom_range(1, 3);
      resync = (hold > 0);
      if ($urandom_range(0, 2999) == 0) begin
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end
    resync = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
